// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch slice.
`default_nettype none
package if_pkg;

  localparam int NB_INST_DEFAULT = 32;
  localparam int BYTES_PER_WORD  = 4;

  typedef logic [NB_INST_DEFAULT-1:0] inst_t;

  localparam inst_t HALT_INSTR = '1;
  localparam inst_t NOP_INSTR  = '0;

endpackage
`default_nettype wire

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port, one asynchronous read port.
`default_nettype none
module instr_mem #(
  parameter int NB_ADDR = 6,
  parameter int NB_INST = 32
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_INST-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_INST-1:0] o_rdata
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_INST-1:0] mem_q [DEPTH];

  // Contents survive reset; the read is combinational so a same-cycle write returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_latch.sv
// Byte-serial program loader, instruction memory and IF/ID pipeline latch.
// Optional feature: define IF_HALT_DETECT_EN to freeze the latch on a latched HALT instruction.
`default_nettype none
module if_fetch_latch
  import if_pkg::*;
#(
  parameter int NB_PC   = 8,
  parameter int NB_INST = NB_INST_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_byte,
  output logic               o_load_full,
  input  logic [NB_PC-1:0]   i_PC,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [NB_INST-1:0] o_instr,
  output logic [NB_PC-1:0]   o_PC4,
  output logic               o_valid,
  output logic               o_halt
);

  localparam int NB_ADDR   = NB_PC - 2;
  localparam int NB_LANES  = (BYTES_PER_WORD - 1) * 8;
  localparam int NB_WORD   = BYTES_PER_WORD * 8;

  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [NB_ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [NB_LANES-1:0] lanes_q, lanes_d;
  logic                load_full_q, load_full_d;
  logic                mem_we;
  logic [NB_WORD-1:0]  w_word;
  logic [NB_INST-1:0]  mem_rdata;

  logic [NB_INST-1:0]  instr_q, instr_d;
  logic [NB_PC-1:0]    pc4_q, pc4_d;
  logic                valid_q, valid_d;
  logic                w_freeze;
  logic                w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^i_PC[1:0];
  assign w_word          = {i_load_byte, lanes_q};

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    lanes_d     = lanes_q;
    load_full_d = load_full_q;
    mem_we      = 1'b0;
    if (i_load_valid && !load_full_q) begin
      if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        mem_we     = 1'b1;
        byte_cnt_d = 2'd0;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        if (wr_ptr_q == '1) load_full_d = 1'b1;
      end else begin
        lanes_d[{byte_cnt_q, 3'b000} +: 8] = i_load_byte;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  instr_mem #(
    .NB_ADDR (NB_ADDR),
    .NB_INST (NB_INST)
  ) u_instr_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (NB_INST'(w_word)),
    .i_raddr (i_PC[NB_PC-1:2]),
    .o_rdata (mem_rdata)
  );

`ifdef IF_HALT_DETECT_EN
  // The latch holds itself once HALT is captured, so this stays high until reset.
  assign w_freeze = valid_q && (instr_q == NB_INST'(HALT_INSTR));
`else
  assign w_freeze = 1'b0;
`endif

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!w_freeze) begin
      if (i_flush) begin
        instr_d = NB_INST'(NOP_INSTR);
        valid_d = 1'b0;
      end else if (!i_stall) begin
        instr_d = mem_rdata;
        pc4_d   = i_PC + NB_PC'(4);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      byte_cnt_q  <= 2'd0;
      wr_ptr_q    <= '0;
      lanes_q     <= '0;
      load_full_q <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      lanes_q     <= lanes_d;
      load_full_q <= load_full_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign o_load_full = load_full_q;
  assign o_instr     = instr_q;
  assign o_PC4       = pc4_q;
  assign o_valid     = valid_q;
  assign o_halt      = w_freeze;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_latch.sv
// Scoreboard bench for if_fetch_latch: stimulus pushes expectations, a negedge monitor checks them.
`default_nettype none
module tb_if_fetch_latch;

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_full;
  logic [7:0]  pc;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [7:0]  pc4;
  logic        valid;
  logic        halt;

  if_fetch_latch #(.NB_PC(8), .NB_INST(32)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_load_valid (load_valid),
    .i_load_byte  (load_byte),
    .o_load_full  (load_full),
    .i_PC         (pc),
    .i_stall      (stall),
    .i_flush      (flush),
    .o_instr      (instr),
    .o_PC4        (pc4),
    .o_valid      (valid),
    .o_halt       (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_l;
    logic [31:0] instr;
    logic [7:0]  pc4;
    logic        valid;
    logic        halt;
    bit          chk_f;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   checks    = 0;
  int   failures  = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  exp_t m;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      m = sb.pop_front();
      if (m.cyc < cycle_cnt) begin
        checks++;
        failures++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", m.name, m.cyc, cycle_cnt);
      end else begin
        if (m.chk_l) begin
          checks++;
          if (instr !== m.instr || pc4 !== m.pc4 || valid !== m.valid || halt !== m.halt) begin
            failures++;
            $display("FAIL %s: got instr=%h pc4=%0d valid=%b halt=%b, want instr=%h pc4=%0d valid=%b halt=%b",
                     m.name, instr, pc4, valid, halt, m.instr, m.pc4, m.valid, m.halt);
          end
        end
        if (m.chk_f) begin
          checks++;
          if (load_full !== m.full) begin
            failures++;
            $display("FAIL %s: got load_full=%b, want %b", m.name, load_full, m.full);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic lv, input logic [7:0] lb,
                       input logic [7:0] p, input logic st, input logic fl);
    rst = r; load_valid = lv; load_byte = lb; pc = p; stall = st; flush = fl;
  endtask

  function automatic void exp_l(string n, logic [31:0] ins, logic [7:0] p4, logic v, logic h);
    exp_t e;
    e.cyc = cycle_cnt + 1; e.name = n; e.chk_l = 1'b1; e.instr = ins; e.pc4 = p4;
    e.valid = v; e.halt = h; e.chk_f = 1'b0; e.full = 1'b0;
    sb.push_back(e);
  endfunction

  function automatic void exp_f(string n, logic f);
    exp_t e;
    e.cyc = cycle_cnt + 1; e.name = n; e.chk_l = 1'b0; e.instr = '0; e.pc4 = '0;
    e.valid = 1'b0; e.halt = 1'b0; e.chk_f = 1'b1; e.full = f;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] word_val(int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (k == 0) return 32'h2000_0013;
    if (k == 2) return 32'hFFFF_FFFF;
    return {8'hA5, kb, 8'h5A, kb};
  endfunction

  initial begin
    logic [31:0] w;
    drive(1, 0, 8'h00, 8'd0, 0, 0);
    exp_l("reset_latch", 32'h0, 8'd0, 1'b0, 1'b0);
    exp_f("reset_full", 1'b0);
    tick();

    // Partial word, then reset: those two bytes must be discarded.
    drive(0, 1, 8'hAA, 8'd0, 1, 0); tick();
    drive(0, 1, 8'hBB, 8'd0, 1, 0); tick();
    drive(1, 0, 8'h00, 8'd0, 1, 0); tick();
    drive(0, 1, 8'h13, 8'd0, 1, 0); tick();
    drive(0, 1, 8'h00, 8'd0, 1, 0); tick();
    drive(0, 1, 8'h00, 8'd0, 1, 0); tick();
    drive(0, 1, 8'h20, 8'd0, 1, 0); tick();
    drive(0, 0, 8'h00, 8'd0, 0, 0);
    exp_l("fetch_w0", 32'h2000_0013, 8'd4, 1'b1, 1'b0);
    tick();

    for (int k = 1; k < 64; k++) begin
      w = word_val(k);
      for (int b = 0; b < 4; b++) begin
        drive(0, 1, w[b*8 +: 8], 8'd0, 1, 0);
        if (k == 63 && b == 2) exp_f("full_before_last", 1'b0);
        if (k == 63 && b == 3) exp_f("full_after_256", 1'b1);
        tick();
      end
    end

    for (int b = 0; b < 4; b++) begin
      drive(0, 1, 8'h77, 8'd0, 1, 0); tick();
    end
    drive(0, 0, 8'h00, 8'd0, 0, 0);
    exp_l("drop_after_full", 32'h2000_0013, 8'd4, 1'b1, 1'b0);
    exp_f("full_sticky", 1'b1);
    tick();

    drive(0, 0, 8'h00, 8'd4, 0, 0);  exp_l("fetch_pc4", 32'hA501_5A01, 8'd8, 1'b1, 1'b0);  tick();
    drive(0, 0, 8'h00, 8'd6, 0, 0);  exp_l("fetch_pc6", 32'hA501_5A01, 8'd10, 1'b1, 1'b0); tick();
    drive(0, 0, 8'h00, 8'd12, 1, 1); exp_l("flush_over_stall", 32'h0, 8'd10, 1'b0, 1'b0); tick();
    drive(0, 0, 8'h00, 8'd16, 0, 0); exp_l("fetch_pc16", 32'hA504_5A04, 8'd20, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 8'd24, 1, 0);
      exp_l($sformatf("stall_hold_%0d", i), 32'hA504_5A04, 8'd20, 1'b1, 1'b0);
      tick();
    end
    drive(0, 0, 8'h00, 8'd252, 0, 0); exp_l("pc4_wrap", 32'hA53F_5A3F, 8'd0, 1'b1, 1'b0); tick();

    drive(1, 1, 8'h55, 8'd4, 0, 1);
    exp_l("reset2_latch", 32'h0, 8'd0, 1'b0, 1'b0);
    exp_f("reset2_full", 1'b0);
    tick();

    // Rewrite word 0 while fetching it on the same edge: old contents come back.
    drive(0, 1, 8'hEE, 8'd0, 0, 0); tick();
    drive(0, 1, 8'hFF, 8'd0, 0, 0); tick();
    drive(0, 1, 8'hC0, 8'd0, 0, 0); tick();
    drive(0, 1, 8'h00, 8'd0, 0, 0);
    exp_l("read_before_write", 32'h2000_0013, 8'd4, 1'b1, 1'b0);
    tick();
    drive(0, 0, 8'h00, 8'd0, 0, 0);
    exp_l("fetch_new_w0", 32'h00C0_FFEE, 8'd4, 1'b1, 1'b0);
    exp_f("full_after_one_word", 1'b0);
    tick();

    drive(0, 0, 8'h00, 8'd8, 0, 0);
    exp_l("halt_fetch", 32'hFFFF_FFFF, 8'd12, 1'b1, HALT_ON);
    tick();
    drive(0, 0, 8'h00, 8'd12, 0, 0);
    exp_l("after_halt", HALT_ON ? 32'hFFFF_FFFF : 32'hA503_5A03, HALT_ON ? 8'd12 : 8'd16, 1'b1, HALT_ON);
    tick();
    drive(0, 0, 8'h00, 8'd16, 0, 1);
    exp_l("flush_after_halt", HALT_ON ? 32'hFFFF_FFFF : 32'h0, HALT_ON ? 8'd12 : 8'd16, HALT_ON, HALT_ON);
    tick();
    drive(1, 0, 8'h00, 8'd16, 0, 0);
    exp_l("reset3_latch", 32'h0, 8'd0, 1'b0, 1'b0);
    tick();

    drive(0, 0, 8'h00, 8'd0, 1, 0);
    tick(); tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cycle_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
